// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point multiply/round blocks.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    // Bit positions inside the 4-bit flags vector.
    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN {0, EMAX, 1, 0...}, zero-extended to 64 bits.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (64'(fp_emax(exp_w)) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand with guard/sticky bits.
module fp_round_rne #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W:0]         sig_in,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [MAN_W:0]         sig_out,
    output logic signed [EXP_W+1:0] exp_out,
    output logic                   inexact
);
    localparam logic signed [EXP_W+1:0] ONE_S = (EXP_W+2)'(1);

    logic           round_up;
    logic [MAN_W+1:0] sum;

    // Round up on guard with sticky or odd lsb; a carry-out renormalises to 1.0
    always_comb begin
        round_up = guard & (sticky | sig_in[0]);
        sum      = {1'b0, sig_in} + {{(MAN_W+1){1'b0}}, round_up};
        inexact  = guard | sticky;
        if (sum[MAN_W+1]) begin
            sig_out = sum[MAN_W+1:1];
            exp_out = exp_in + ONE_S;
        end else begin
            sig_out = sum[MAN_W:0];
            exp_out = exp_in;
        end
    end

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle FP multiplier: shift-add significand product, RNE rounding, flags.
module fp_multiplier_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     c,
    output logic [3:0]               flags
);
    import fp_pkg::*;

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX_S = EW'(fp_emax(EXP_W));
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = EW'(0);
    localparam logic [EXP_W-1:0]     EMAX_F = '1;
    localparam logic [63:0]          QNAN64 = fp_qnan(EXP_W, MAN_W);

    state_t state_q, state_d;

    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [PW-1:0]        acc, mcand;
    logic [SW-1:0]        mplier;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        sig_q;
    logic                 guard_q, sticky_q;

    // Operand decode; subnormals count as zero
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign ea     = a[W-2:MAN_W];
    assign eb     = b[W-2:MAN_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign s      = a[W-1] ^ b[W-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EMAX_F) && (fa == '0);
    assign b_inf  = (eb == EMAX_F) && (fb == '0);
    assign a_nan  = (ea == EMAX_F) && (fa != '0);
    assign b_nan  = (eb == EMAX_F) && (fb != '0);

    logic         spec_hit;
    logic [W-1:0] spec_c;
    logic [3:0]   spec_flags;

    // Special-value results that bypass the multiplier
    always_comb begin
        spec_hit   = 1'b1;
        spec_c     = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_c               = QNAN64[W-1:0];
            spec_flags[FLAG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_c = {s, EMAX_F, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_c = {s, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [SW-1:0]        norm_sig;
    logic                 norm_guard, norm_sticky;
    logic signed [EW-1:0] norm_exp;

    // Product lies in [1,4): pick the leading one and split off guard/sticky
    always_comb begin
        if (acc[PW-1]) begin
            norm_sig    = acc[PW-1:SW];
            norm_guard  = acc[SW-1];
            norm_sticky = |acc[SW-2:0];
            norm_exp    = exp_q + ONE_S;
        end else begin
            norm_sig    = acc[PW-2:SW-1];
            norm_guard  = acc[SW-2];
            norm_sticky = |acc[SW-3:0];
            norm_exp    = exp_q;
        end
    end

    logic [SW-1:0]        rnd_sig;
    logic signed [EW-1:0] rnd_exp;
    logic                 rnd_inexact;
    logic                 unused_hidden;
    assign unused_hidden = rnd_sig[MAN_W];

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sig_in  (sig_q),
        .guard   (guard_q),
        .sticky  (sticky_q),
        .exp_in  (exp_q),
        .sig_out (rnd_sig),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact)
    );

    logic [W-1:0] res_c;
    logic [3:0]   res_flags;

    // Final packing with overflow saturation to inf and underflow flush to zero
    always_comb begin
        res_flags           = '0;
        res_flags[FLAG_INX] = rnd_inexact;
        res_c               = {sign_q, rnd_exp[EXP_W-1:0], rnd_sig[MAN_W-1:0]};
        if (rnd_exp >= EMAX_S) begin
            res_c               = {sign_q, EMAX_F, {MAN_W{1'b0}}};
            res_flags[FLAG_OVF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end else if (rnd_exp <= ZERO_S) begin
            res_c               = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            res_flags[FLAG_UNF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (in_valid) state_d = spec_hit ? DONE : MULT;
            MULT:    if (cnt == CW'(MAN_W)) state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, one shift-add step per MULT cycle, normalise, round
    always_ff @(posedge CLK) begin
        if (RST) begin
            c        <= '0;
            flags    <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            sig_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    sign_q <= s;
                    if (spec_hit) begin
                        c     <= spec_c;
                        flags <= spec_flags;
                    end else begin
                        exp_q  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
                        mcand  <= {{(PW-SW){1'b0}}, 1'b1, fa};
                        mplier <= {1'b1, fb};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                NORM: begin
                    sig_q    <= norm_sig;
                    guard_q  <= norm_guard;
                    sticky_q <= norm_sticky;
                    exp_q    <= norm_exp;
                end
                ROUND: begin
                    c     <= res_c;
                    flags <= res_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
